uart_transceiver: RTL and testbench



---
 rtl/uart_transceiver.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_uart_transceiver.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transceiver.sv
// uart_transceiver: parametrised full-duplex UART with a serial transmitter
// and an oversampling receiver. Both sides use valid/ready handshakes
// toward the host.
//
// Optional feature macro: UART_PARITY_EN
//   defined   : a parity bit follows the data bits (even, or odd when
//               PARITY_ODD=1); the receiver checks it and drives rx_parity_err.
//   undefined : no parity bit; rx_parity_err is tied low.
//
// Ports:
//   clk, rst       system clock (rising edge), asynchronous active-high reset
//   tx_data        payload to transmit, captured on tx_valid && tx_ready
//   tx_valid       host offers tx_data
//   tx_ready       transmitter idle, able to accept a frame
//   tx             serial output, idle high
//   rx             serial input, asynchronous to clk
//   rx_data        last received payload
//   rx_valid       rx_data holds an unread frame
//   rx_ready       host consumes rx_data
//   rx_parity_err  one-cycle pulse, parity mismatch on the delivered frame
//   rx_frame_err   one-cycle pulse, stop bit sampled low
//   rx_overrun     one-cycle pulse, frame completed while rx_valid was high
module uart_transceiver #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = $clog2(DIV + 1);
    localparam int TW      = $clog2(OVERSAMPLE);

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
`ifdef UART_PARITY_EN
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);
`endif

    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 8 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_transceiver: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t               tx_state;
    logic [DW-1:0]        tx_div_cnt;
    logic [TW-1:0]        tx_tick_cnt;
    logic [3:0]           tx_bit_cnt;
    logic [DATA_BITS-1:0] tx_shreg;
    logic                 tx_bit_end;
`ifdef UART_PARITY_EN
    logic                 tx_par;
`endif

    assign tx_bit_end = (tx_div_cnt == DIV_LAST) && (tx_tick_cnt == TICK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state    <= S_IDLE;
            tx          <= 1'b1;
            tx_ready    <= 1'b1;
            tx_div_cnt  <= '0;
            tx_tick_cnt <= '0;
            tx_bit_cnt  <= '0;
            tx_shreg    <= '0;
`ifdef UART_PARITY_EN
            tx_par      <= 1'b0;
`endif
        end else begin
            if (tx_state != S_IDLE) begin
                if (tx_div_cnt == DIV_LAST) begin
                    tx_div_cnt  <= '0;
                    tx_tick_cnt <= (tx_tick_cnt == TICK_LAST) ? '0 : tx_tick_cnt + TW'(1);
                end else begin
                    tx_div_cnt <= tx_div_cnt + DW'(1);
                end
            end

            case (tx_state)
                S_IDLE: begin
                    // tx_ready re-arms one cycle after the frame ends
                    if (tx_ready && tx_valid) begin
                        tx_shreg    <= tx_data;
                        tx_state    <= S_START;
                        tx          <= 1'b0;
                        tx_ready    <= 1'b0;
                        tx_div_cnt  <= '0;
                        tx_tick_cnt <= '0;
                        tx_bit_cnt  <= '0;
`ifdef UART_PARITY_EN
                        tx_par      <= (^tx_data) ^ PAR_ODD;
`endif
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end
                S_START: begin
                    if (tx_bit_end) begin
                        tx       <= tx_shreg[0];
                        tx_shreg <= {1'b0, tx_shreg[DATA_BITS-1:1]};
                        tx_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tx_bit_end) begin
                        if (tx_bit_cnt == DATA_LAST) begin
                            tx_bit_cnt <= '0;
`ifdef UART_PARITY_EN
                            tx         <= tx_par;
                            tx_state   <= S_PARITY;
`else
                            tx         <= 1'b1;
                            tx_state   <= S_STOP;
`endif
                        end else begin
                            tx_bit_cnt <= tx_bit_cnt + 4'd1;
                            tx         <= tx_shreg[0];
                            tx_shreg   <= {1'b0, tx_shreg[DATA_BITS-1:1]};
                        end
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (tx_bit_end) begin
                        tx         <= 1'b1;
                        tx_bit_cnt <= '0;
                        tx_state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (tx_bit_end) begin
                        if (tx_bit_cnt == STOP_LAST) begin
                            tx_state <= S_IDLE;
                        end else begin
                            tx_bit_cnt <= tx_bit_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    tx_state <= S_IDLE;
                    tx       <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic                 rx_s1;
    logic                 rx_s2;
    state_t               rx_state;
    logic [DW-1:0]        rx_div_cnt;
    logic [TW-1:0]        rx_tick_cnt;
    logic [3:0]           rx_bit_cnt;
    logic [DATA_BITS-1:0] rx_shreg;
    logic                 rx_tick;
    logic                 rx_sample;
`ifdef UART_PARITY_EN
    logic                 rx_par_bit;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
        end
    end

    // Start bit is checked half a bit in; every later sample is a full bit on
    assign rx_tick   = (rx_div_cnt == DIV_LAST);
    assign rx_sample = rx_tick && (rx_tick_cnt == ((rx_state == S_START) ? TICK_HALF : TICK_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state      <= S_IDLE;
            rx_div_cnt    <= '0;
            rx_tick_cnt   <= '0;
            rx_bit_cnt    <= '0;
            rx_shreg      <= '0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bit    <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (rx_tick) begin
                rx_div_cnt  <= '0;
                rx_tick_cnt <= (rx_tick_cnt == TICK_LAST) ? '0 : rx_tick_cnt + TW'(1);
            end else begin
                rx_div_cnt <= rx_div_cnt + DW'(1);
            end

            case (rx_state)
                S_IDLE: begin
                    if (!rx_s2) begin
                        rx_state    <= S_START;
                        rx_div_cnt  <= '0;
                        rx_tick_cnt <= '0;
                    end
                end
                S_START: begin
                    if (rx_sample) begin
                        if (rx_s2) begin
                            rx_state <= S_IDLE;
                        end else begin
                            rx_state    <= S_DATA;
                            rx_tick_cnt <= '0;
                            rx_bit_cnt  <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_sample) begin
                        rx_shreg <= {rx_s2, rx_shreg[DATA_BITS-1:1]};
                        if (rx_bit_cnt == DATA_LAST) begin
`ifdef UART_PARITY_EN
                            rx_state <= S_PARITY;
`else
                            rx_state <= S_STOP;
`endif
                        end else begin
                            rx_bit_cnt <= rx_bit_cnt + 4'd1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (rx_sample) begin
                        rx_par_bit <= rx_s2;
                        rx_state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (rx_sample) begin
                        rx_state <= S_IDLE;
                        if (!rx_s2) begin
                            rx_frame_err <= 1'b1;
                        end else if (!rx_valid || rx_ready) begin
                            // covers consume-and-load: the load wins over the clear
                            rx_data  <= rx_shreg;
                            rx_valid <= 1'b1;
`ifdef UART_PARITY_EN
                            rx_parity_err <= rx_par_bit ^ (^rx_shreg) ^ PAR_ODD;
`endif
                        end else begin
                            rx_overrun <= 1'b1;
                        end
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

`ifndef UART_PARITY_EN
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_transceiver.sv
module tb_uart_transceiver;

    localparam int DB       = 8;
    localparam int BIT_CLKS = 160;
    localparam int PODD     = 0;
`ifdef UART_PARITY_EN
    localparam int PB       = 1;
    localparam int EXP_PERR = 1;
`else
    localparam int PB       = 0;
    localparam int EXP_PERR = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DB-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          tx;
    logic          rx = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic          rx_parity_err;
    logic          rx_frame_err;
    logic          rx_overrun;

    uart_transceiver #(
        .CLK_FREQ  (1536000),
        .BAUD      (9600),
        .OVERSAMPLE(16),
        .DATA_BITS (DB),
        .STOP_BITS (1),
        .PARITY_ODD(PODD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx           (tx),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_parity_err(rx_parity_err),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int n_ferr   = 0;
    int n_ovr    = 0;
    int n_perr   = 0;

    typedef struct {
        logic [DB-1:0] data;
        logic          perr;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: error pulses are tallied, every new delivery is
    // matched against the oldest expected frame.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (rx_frame_err)  n_ferr++;
            if (rx_overrun)    n_ovr++;
            if (rx_parity_err) n_perr++;
            if (rx_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("rx_unexpected_delivery", 32'(rx_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e.data));
                    check("rx_parity_err_with_valid", 32'(rx_parity_err), 32'(e.perr));
                end
            end
            prev_valid = rx_valid;
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic par_of(input logic [DB-1:0] d);
        return (^d) ^ (PODD != 0);
    endfunction

    // Drives one frame on rx. A low stop bit is held low past the sample
    // point, then released so the tail is not mistaken for a new start.
    task automatic send_rx(input logic [DB-1:0] d, input logic par_bit, input logic stop_bit);
        @(posedge clk);
        #1;
        rx = 1'b0;
        clks(BIT_CLKS);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            clks(BIT_CLKS);
        end
        if (PB != 0) begin
            rx = par_bit;
            clks(BIT_CLKS);
        end
        if (stop_bit) begin
            rx = 1'b1;
            clks(BIT_CLKS);
        end else begin
            rx = 1'b0;
            clks(120);
            rx = 1'b1;
            clks(40);
        end
        rx = 1'b1;
    endtask

    task automatic consume(input string tag);
        check({tag, "_valid_before_ready"}, 32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        @(negedge clk);
        check({tag, "_valid_until_edge"}, 32'(rx_valid), 32'd1);
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        @(negedge clk);
        check({tag, "_valid_cleared"}, 32'(rx_valid), 32'd0);
    endtask

    // Sends one frame and checks tx at every bit centre plus ready timing;
    // k counts clocks after the accepting edge.
    task automatic tx_frame(input logic [DB-1:0] d, input string tag);
        logic [15:0] bits;
        int nb;
        nb = 2 + DB + PB;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < DB; i++) bits[1+i] = d[i];
        if (PB != 0) bits[1+DB] = par_of(d);
        check({tag, "_ready_before"}, 32'(tx_ready), 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        for (int k = 0; k <= nb * BIT_CLKS + 1; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check({tag, "_tx_low_after_accept"}, 32'(tx), 32'd0);
                check({tag, "_ready_drops"}, 32'(tx_ready), 32'd0);
            end
            if (k == BIT_CLKS - 1) check({tag, "_start_end"}, 32'(tx), 32'd0);
            if ((k % BIT_CLKS) == BIT_CLKS / 2 && (k / BIT_CLKS) < nb)
                check($sformatf("%s_bit%0d", tag, k / BIT_CLKS), 32'(tx), 32'(bits[k/BIT_CLKS]));
            if (k == nb * BIT_CLKS) begin
                check({tag, "_ready_low_at_frame_end"}, 32'(tx_ready), 32'd0);
                check({tag, "_tx_idle_high"}, 32'(tx), 32'd1);
            end
            if (k == nb * BIT_CLKS + 1) check({tag, "_ready_back"}, 32'(tx_ready), 32'd1);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_errs", 32'({rx_parity_err, rx_frame_err, rx_overrun}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clks(3);

        // Transmit
        tx_frame(8'h23, "tx23");
        clks(5);
        tx_frame(8'hC4, "txC4");
        clks(5);

        // Clean receive
        exp_q.push_back('{data: 8'h51, perr: 1'b0});
        send_rx(8'h51, par_of(8'h51), 1'b1);
        check("rx51_no_errs", 32'(n_ferr + n_ovr + n_perr), 32'd0);
        consume("rx51");

        // Start-bit glitch
        rx = 1'b0;
        clks(40);
        rx = 1'b1;
        clks(300);
        check("glitch_no_valid", 32'(rx_valid), 32'd0);
        check("glitch_no_errs", 32'(n_ferr + n_ovr + n_perr), 32'd0);
        exp_q.push_back('{data: 8'h3C, perr: 1'b0});
        send_rx(8'h3C, par_of(8'h3C), 1'b1);
        consume("rx3C");

        // Framing error
        send_rx(8'hA5, par_of(8'hA5), 1'b0);
        clks(200);
        check("ferr_count", 32'(n_ferr), 32'd1);
        check("ferr_no_valid", 32'(rx_valid), 32'd0);
        exp_q.push_back('{data: 8'h5A, perr: 1'b0});
        send_rx(8'h5A, par_of(8'h5A), 1'b1);
        consume("rx5A");

        // Overrun
        exp_q.push_back('{data: 8'h11, perr: 1'b0});
        send_rx(8'h11, par_of(8'h11), 1'b1);
        send_rx(8'h22, par_of(8'h22), 1'b1);
        clks(20);
        check("ovr_count", 32'(n_ovr), 32'd1);
        check("ovr_data_held", 32'(rx_data), 32'h11);
        check("ovr_valid_held", 32'(rx_valid), 32'd1);
        check("ovr_ferr_unchanged", 32'(n_ferr), 32'd1);
        consume("rx11");

`ifdef UART_PARITY_EN
        tx_frame(8'h07, "tx07par");
        clks(5);
        exp_q.push_back('{data: 8'h07, perr: 1'b1});
        send_rx(8'h07, ~par_of(8'h07), 1'b1);
        consume("rx07bad");
`endif
        check("perr_count", 32'(n_perr), 32'(EXP_PERR));

        // Reset in the middle of a transmitted frame (all-zero data keeps tx low)
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        clks(500);
        #2;
        check("midtx_tx_low", 32'(tx), 32'd0);
        rst = 1'b1;
        #1;
        check("midtx_rst_tx_high", 32'(tx), 32'd1);
        check("midtx_rst_ready", 32'(tx_ready), 32'd1);
        clks(3);
        rst = 1'b0;
        clks(2);
        check("after_rst_ready", 32'(tx_ready), 32'd1);
        check("after_rst_tx", 32'(tx), 32'd1);
        check("after_rst_rx_valid", 32'(rx_valid), 32'd0);
        clks(BIT_CLKS * 2);
        check("after_rst_tx_idle", 32'(tx), 32'd1);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
